// File: rtl/div_share_sched_pkg.sv
// Shared types and defaults for the shared-divider scheduler.
package fm_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3
  } div_sched_state_t;

  localparam int DIV_TIMEOUT_DEFAULT = 96;

endpackage

// File: rtl/div_share_sched_arb.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic          hi_any_s;
  logic          lo_any_s;
  logic [IW-1:0] hi_idx_s;
  logic [IW-1:0] lo_idx_s;

  // Lowest request at/above ptr wins; otherwise wrap to the lowest request overall
  always_comb begin
    hi_any_s = 1'b0;
    lo_any_s = 1'b0;
    hi_idx_s = '0;
    lo_idx_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_any_s = 1'b1;
        lo_idx_s = IW'(i);
        if (IW'(i) >= ptr) begin
          hi_any_s = 1'b1;
          hi_idx_s = IW'(i);
        end else begin
          hi_any_s = hi_any_s;
        end
      end else begin
        lo_any_s = lo_any_s;
      end
    end
    if (hi_any_s) begin
      grant_idx = hi_idx_s;
    end else begin
      grant_idx = lo_idx_s;
    end
    any = lo_any_s;
    if (lo_any_s) begin
      grant = ONE << grant_idx;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one multi-cycle divider among N_REQ clients,
// with divide-by-zero short-circuit and a watchdog for a hung divider.
module div_share_sched
  import fm_div_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int DVD_W   = 64,
  parameter int DVS_W   = 32,
  parameter int TIMEOUT = DIV_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*DVD_W-1:0] req_dividend,
  input  logic [N_REQ*DVS_W-1:0] req_divisor,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [DVD_W-1:0]       rsp_quotient,
  output logic [DVS_W-1:0]       rsp_remainder,
  output logic                   rsp_overflow,
  output logic                   rsp_timeout,
  output logic                   busy,
  output logic                   div_valid_in,
  output logic [DVD_W-1:0]       div_dividend,
  output logic [DVS_W-1:0]       div_divisor,
  input  logic [DVD_W-1:0]       div_quotient,
  input  logic [DVS_W-1:0]       div_remainder,
  input  logic                   div_overflow,
  input  logic                   div_valid_out
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  div_sched_state_t  state_r;
  logic [IW-1:0]     rr_ptr_r;
  logic [IW-1:0]     owner_r;
  logic [WW-1:0]     wdog_r;
  logic [N_REQ-1:0]  rsp_valid_r;
  logic [DVD_W-1:0]  rsp_quotient_r;
  logic [DVS_W-1:0]  rsp_remainder_r;
  logic              rsp_overflow_r;
  logic              rsp_timeout_r;
  logic              busy_r;
  logic              div_valid_in_r;
  logic [DVD_W-1:0]  div_dividend_r;
  logic [DVS_W-1:0]  div_divisor_r;

  logic [N_REQ-1:0]  grant_s;
  logic [IW-1:0]     grant_idx_s;
  logic              any_s;
  logic              accept_s;
  logic [DVD_W-1:0]  sel_dividend_s;
  logic [DVS_W-1:0]  sel_divisor_s;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any       (any_s)
  );

  // Operand mux for the granted client (AND-OR over the one-hot grant)
  always_comb begin
    sel_dividend_s = '0;
    sel_divisor_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_dividend_s = sel_dividend_s | ({DVD_W{grant_s[i]}} & req_dividend[i*DVD_W +: DVD_W]);
      sel_divisor_s  = sel_divisor_s  | ({DVS_W{grant_s[i]}} & req_divisor[i*DVS_W +: DVS_W]);
    end
  end

  // Ready only in IDLE so a single op is ever outstanding
  always_comb begin
    if ((state_r == S_IDLE) && !reset) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
    accept_s = (state_r == S_IDLE) && any_s;
  end

  // Scheduler FSM with registered operands, results and strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= S_IDLE;
      rr_ptr_r        <= '0;
      owner_r         <= '0;
      wdog_r          <= '0;
      rsp_valid_r     <= '0;
      rsp_quotient_r  <= '0;
      rsp_remainder_r <= '0;
      rsp_overflow_r  <= 1'b0;
      rsp_timeout_r   <= 1'b0;
      busy_r          <= 1'b0;
      div_valid_in_r  <= 1'b0;
      div_dividend_r  <= '0;
      div_divisor_r   <= '0;
    end else begin
      rsp_valid_r    <= '0;
      div_valid_in_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            owner_r        <= grant_idx_s;
            rr_ptr_r       <= (grant_idx_s == IW'(N_REQ - 1)) ? '0 : grant_idx_s + IW'(1);
            div_dividend_r <= sel_dividend_s;
            div_divisor_r  <= sel_divisor_s;
            busy_r         <= 1'b1;
            if (sel_divisor_s == '0) begin
              // Divider is bypassed entirely on divide-by-zero
              rsp_quotient_r  <= {DVD_W{1'b1}};
              rsp_remainder_r <= sel_dividend_s[DVS_W-1:0];
              rsp_overflow_r  <= 1'b1;
              rsp_timeout_r   <= 1'b0;
              rsp_valid_r     <= grant_s;
              state_r         <= S_RESP;
            end else begin
              div_valid_in_r <= 1'b1;
              state_r        <= S_ISSUE;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ISSUE: begin
          wdog_r  <= '0;
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          wdog_r <= wdog_r + WW'(1);
          if (div_valid_out) begin
            rsp_quotient_r  <= div_quotient;
            rsp_remainder_r <= div_remainder;
            rsp_overflow_r  <= div_overflow;
            rsp_timeout_r   <= 1'b0;
            rsp_valid_r     <= ONE << owner_r;
            state_r         <= S_RESP;
          end else if (wdog_r == WW'(TIMEOUT - 1)) begin
            rsp_quotient_r  <= {DVD_W{1'b1}};
            rsp_remainder_r <= '0;
            rsp_overflow_r  <= 1'b1;
            rsp_timeout_r   <= 1'b1;
            rsp_valid_r     <= ONE << owner_r;
            state_r         <= S_RESP;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_RESP: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_r;
  assign rsp_quotient  = rsp_quotient_r;
  assign rsp_remainder = rsp_remainder_r;
  assign rsp_overflow  = rsp_overflow_r;
  assign rsp_timeout   = rsp_timeout_r;
  assign busy          = busy_r;
  assign div_valid_in  = div_valid_in_r;
  assign div_dividend  = div_dividend_r;
  assign div_divisor   = div_divisor_r;

endmodule
